// File: rtl/axi_pkg.sv
// Shared response codes and FSM state encodings for the burst memory slave.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } w_state_t;

endpackage

// File: rtl/axi_slave_mem_array.sv
// Word-addressed register array: one synchronous write port, one async read port.
// Contents come up as mem[i] = i + INIT_OFFSET and are never cleared by reset.
module axi_slave_mem_array #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_AW      = 6,
  parameter int INIT_OFFSET = 50
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [MEM_AW-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [MEM_AW-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 32'd1 << MEM_AW;

  function automatic logic [DEPTH-1:0][DATA_WIDTH-1:0] init_image();
    logic [DEPTH-1:0][DATA_WIDTH-1:0] img;
    for (int i = 0; i < DEPTH; i++) begin
      img[i] = DATA_WIDTH'(i + INIT_OFFSET);
    end
    return img;
  endfunction

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem = init_image();

  // Write port; a read of the same word in this cycle still sees the old value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI-style INCR burst memory responder with independent read and write engines.
// Beats addressed at or beyond the memory depth return SLVERR and never touch storage.
module axi_burst_mem_slave
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int MEM_AW      = 6,
  parameter int INIT_OFFSET = 50
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [LEN_WIDTH-1:0]  arlen,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [LEN_WIDTH-1:0]  awlen,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wlast,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp
);

  localparam int HI_W = ADDR_WIDTH - MEM_AW;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]  LEN_STEP  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr[ADDR_WIDTH-1:MEM_AW] == {HI_W{1'b0}});
  endfunction

  r_state_t r_state;
  w_state_t w_state;

  logic [ADDR_WIDTH-1:0] r_addr_r, w_addr_r, rd_addr_s;
  logic [LEN_WIDTH-1:0]  r_len_r, r_cnt_r, r_cnt_next_s, w_len_r, w_cnt_r;
  logic [DATA_WIDTH-1:0] mem_rdata_s;
  logic rd_ok_s, w_beat_s, w_ok_s, w_at_len_s, w_end_s, w_beat_err_s, w_err_r, mem_we_s;

  // Read port address: the AR address when idle, otherwise the following beat.
  always_comb begin
    rd_addr_s = r_addr_r + ADDR_STEP;
    if (r_state == R_IDLE) begin
      rd_addr_s = araddr;
    end else begin
      rd_addr_s = r_addr_r + ADDR_STEP;
    end
    rd_ok_s      = addr_in_range(rd_addr_s);
    r_cnt_next_s = r_cnt_r + LEN_STEP;
  end

  // Write beat qualification; an early wlast or a missing one both flag the burst.
  always_comb begin
    w_beat_s     = (w_state == W_DATA) && wvalid && wready;
    w_ok_s       = addr_in_range(w_addr_r);
    w_at_len_s   = (w_cnt_r == w_len_r);
    w_end_s      = wlast || w_at_len_s;
    w_beat_err_s = !w_ok_s || (wlast != w_at_len_s);
    mem_we_s     = w_beat_s && w_ok_s;
  end

  axi_slave_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_AW     (MEM_AW),
    .INIT_OFFSET(INIT_OFFSET)
  ) u_slave_mem (
    .clk  (sys_clk),
    .we   (mem_we_s),
    .waddr(w_addr_r[MEM_AW-1:0]),
    .wdata(wdata),
    .raddr(rd_addr_s[MEM_AW-1:0]),
    .rdata(mem_rdata_s)
  );

  // Read engine: load a beat on AR accept and on every non-final R handshake.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state  <= R_IDLE;
      arready  <= 1'b1;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rresp    <= RESP_OKAY;
      rdata    <= DATA_ZERO;
      r_addr_r <= ADDR_ZERO;
      r_len_r  <= LEN_ZERO;
      r_cnt_r  <= LEN_ZERO;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            r_addr_r <= araddr;
            r_len_r  <= arlen;
            r_cnt_r  <= LEN_ZERO;
            rdata    <= rd_ok_s ? mem_rdata_s : DATA_ZERO;
            rresp    <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
            rvalid   <= 1'b1;
            rlast    <= (arlen == LEN_ZERO);
            arready  <= 1'b0;
            r_state  <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid && rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr_r <= rd_addr_s;
              r_cnt_r  <= r_cnt_next_s;
              rdata    <= rd_ok_s ? mem_rdata_s : DATA_ZERO;
              rresp    <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
              rlast    <= (r_cnt_next_s == r_len_r);
            end
          end
        end
        default: begin
          rvalid  <= 1'b0;
          rlast   <= 1'b0;
          arready <= 1'b1;
          r_state <= R_IDLE;
        end
      endcase
    end
  end

  // Write engine: accept AW, absorb W beats, then hold the burst response.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      w_state  <= W_IDLE;
      awready  <= 1'b1;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      w_addr_r <= ADDR_ZERO;
      w_len_r  <= LEN_ZERO;
      w_cnt_r  <= LEN_ZERO;
      w_err_r  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid && awready) begin
            w_addr_r <= awaddr;
            w_len_r  <= awlen;
            w_cnt_r  <= LEN_ZERO;
            w_err_r  <= 1'b0;
            awready  <= 1'b0;
            wready   <= 1'b1;
            w_state  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat_s) begin
            w_addr_r <= w_addr_r + ADDR_STEP;
            w_cnt_r  <= w_cnt_r + LEN_STEP;
            w_err_r  <= w_err_r | w_beat_err_s;
            if (w_end_s) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= (w_err_r || w_beat_err_s) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: begin
          wready  <= 1'b0;
          bvalid  <= 1'b0;
          awready <= 1'b1;
          w_state <= W_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Directed bench for axi_burst_mem_slave: burst reads/writes, stalls, range errors, reset.
module tb_axi_burst_mem_slave;
  import axi_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [1:0]  rresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [7:0]  awlen;
  logic [1:0]  bresp;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_data[$];
  logic [1:0]  got_resp[$];
  logic        got_last[$];
  int          stall_bad;
  logic        first_beat_seen, arready_after, rvalid_after, rd_timeout;
  logic [1:0]  bresp_got;
  logic        wr_timeout, awready_after, bvalid_after;

  axi_burst_mem_slave dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic run_read(input logic [31:0] addr, input logic [7:0] len, input bit toggle);
    int guard;
    bit held, done;
    logic [31:0] held_d;
    logic [1:0] held_r;
    got_data.delete(); got_resp.delete(); got_last.delete();
    stall_bad = 0; rd_timeout = 1'b0; guard = 0; held = 1'b0; done = 1'b0;
    held_d = 32'd0; held_r = 2'd0;
    while (!arready && guard < 50) begin @(posedge sys_clk); #1; guard++; end
    if (!arready) rd_timeout = 1'b1;
    arvalid = 1'b1; araddr = addr; arlen = len; rready = 1'b0;
    @(posedge sys_clk); #1;
    arvalid = 1'b0;
    first_beat_seen = rvalid;
    guard = 0;
    while (!done && guard < 400) begin
      rready = toggle ? (guard % 2 == 0) : 1'b1;
      if (held && (!rvalid || rdata !== held_d || rresp !== held_r)) stall_bad++;
      held = rvalid && !rready; held_d = rdata; held_r = rresp;
      if (rvalid && rready) begin
        got_data.push_back(rdata); got_resp.push_back(rresp); got_last.push_back(rlast);
        done = rlast;
      end
      @(posedge sys_clk); #1; guard++;
    end
    rready = 1'b0;
    if (!done) rd_timeout = 1'b1;
    arready_after = arready; rvalid_after = rvalid;
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                           input int wlast_idx, input logic [31:0] base);
    int guard, i;
    wr_timeout = 1'b0; guard = 0; i = 0;
    while (!awready && guard < 50) begin @(posedge sys_clk); #1; guard++; end
    if (!awready) wr_timeout = 1'b1;
    awvalid = 1'b1; awaddr = addr; awlen = len;
    @(posedge sys_clk); #1;
    awvalid = 1'b0;
    guard = 0;
    while (i < nbeats && guard < 400) begin
      if (wready) begin
        wvalid = 1'b1; wdata = base + 32'(i); wlast = (i == wlast_idx);
      end else begin
        wvalid = 1'b0; wlast = 1'b0;
      end
      @(posedge sys_clk); #1; guard++;
      if (wvalid) i++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (i < nbeats) wr_timeout = 1'b1;
    guard = 0;
    while (!bvalid && guard < 50) begin @(posedge sys_clk); #1; guard++; end
    if (!bvalid) wr_timeout = 1'b1;
    bresp_got = bresp; bready = 1'b1;
    @(posedge sys_clk); #1;
    bready = 1'b0;
    bvalid_after = bvalid; awready_after = awready;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1; sys_rst = 1'b0;
    checks++;
    if ({arready, awready, rvalid, rlast, wready, bvalid} !== 6'b110000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 110000", {arready, awready, rvalid, rlast, wready, bvalid});
    end
    checks++;
    if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %0d expected 0", rdata); end
    checks++;
    if (rresp !== 2'd0 || bresp !== 2'd0) begin
      errors++; $display("FAIL reset_resp: got rresp=%0d bresp=%0d expected 0 0", rresp, bresp);
    end
  endtask

  task automatic test_single_burst_read();
    run_read(32'd15, 8'd2, 1'b0);
    checks++;
    if (first_beat_seen !== 1'b1) begin errors++; $display("FAIL t1_latency: rvalid got %b expected 1", first_beat_seen); end
    checks++;
    if (got_data.size() !== 3 || rd_timeout !== 1'b0) begin
      errors++; $display("FAIL t1_beats: got %0d beats expected 3", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== 32'(65 + i) || got_resp[i] !== RESP_OKAY || got_last[i] !== (i == 2)) begin
        errors++; $display("FAIL t1_beat%0d: got d=%0d r=%0d l=%b expected d=%0d r=0 l=%b", i, got_data[i], got_resp[i], got_last[i], 65 + i, i == 2);
      end
    end
  endtask

  task automatic test_concurrent();
    fork
      run_write(32'd2, 8'd9, 10, 9, 32'd300);
      run_read(32'd25, 8'd19, 1'b0);
    join
    checks++;
    if (wr_timeout !== 1'b0 || bresp_got !== RESP_OKAY) begin
      errors++; $display("FAIL conc_bresp: got %0d timeout=%b expected 0", bresp_got, wr_timeout);
    end
    checks++;
    if (got_data.size() !== 20) begin errors++; $display("FAIL conc_beats: got %0d expected 20", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== 32'(75 + i) || got_resp[i] !== RESP_OKAY || got_last[i] !== (i == 19)) begin
        errors++; $display("FAIL conc_rd%0d: got d=%0d l=%b expected d=%0d", i, got_data[i], got_last[i], 75 + i);
      end
    end
    run_read(32'd2, 8'd9, 1'b0);
    checks++;
    if (got_data.size() !== 10) begin errors++; $display("FAIL conc_verify_beats: got %0d expected 10", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== 32'(300 + i)) begin
        errors++; $display("FAIL conc_verify%0d: got %0d expected %0d", i, got_data[i], 300 + i);
      end
    end
  endtask

  task automatic test_write_burst();
    run_write(32'd8, 8'd19, 20, 19, 32'd100);
    checks++;
    if (wr_timeout !== 1'b0 || bresp_got !== RESP_OKAY) begin
      errors++; $display("FAIL t2_bresp: got %0d timeout=%b expected 0", bresp_got, wr_timeout);
    end
    checks++;
    if (awready_after !== 1'b1 || bvalid_after !== 1'b0) begin
      errors++; $display("FAIL t2_bdone: got awready=%b bvalid=%b expected 1 0", awready_after, bvalid_after);
    end
    run_read(32'd8, 8'd15, 1'b0);
    checks++;
    if (got_data.size() !== 16) begin errors++; $display("FAIL t2_beats: got %0d expected 16", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== 32'(100 + i)) begin errors++; $display("FAIL t2_rd%0d: got %0d expected %0d", i, got_data[i], 100 + i); end
    end
  endtask

  task automatic test_single_beat();
    run_read(32'd8, 8'd0, 1'b0);
    checks++;
    if (got_data.size() !== 1 || got_data[0] !== 32'd100 || got_last[0] !== 1'b1) begin
      errors++; $display("FAIL t3_beat: got n=%0d d=%0d expected n=1 d=100 rlast=1", got_data.size(), got_data[0]);
    end
    checks++;
    if (arready_after !== 1'b1 || rvalid_after !== 1'b0) begin
      errors++; $display("FAIL t3_arready: got arready=%b rvalid=%b expected 1 0", arready_after, rvalid_after);
    end
  endtask

  task automatic test_read_stall();
    run_read(32'd8, 8'd15, 1'b1);
    checks++;
    if (stall_bad !== 0) begin errors++; $display("FAIL t4_stable: got %0d unstable stalls expected 0", stall_bad); end
    checks++;
    if (got_data.size() !== 16 || rd_timeout !== 1'b0) begin
      errors++; $display("FAIL t4_beats: got %0d expected 16", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== 32'(100 + i) || got_last[i] !== (i == 15)) begin
        errors++; $display("FAIL t4_rd%0d: got d=%0d l=%b expected d=%0d", i, got_data[i], got_last[i], 100 + i);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] exp_d[4];
    logic [1:0]  exp_r[4];
    exp_d = '{32'd112, 32'd113, 32'd0, 32'd0};
    exp_r = '{RESP_OKAY, RESP_OKAY, RESP_SLVERR, RESP_SLVERR};
    run_read(32'd62, 8'd3, 1'b0);
    checks++;
    if (got_data.size() !== 4) begin errors++; $display("FAIL t5_beats: got %0d expected 4", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      checks++;
      if (got_data[i] !== exp_d[i] || got_resp[i] !== exp_r[i]) begin
        errors++; $display("FAIL t5_rd%0d: got d=%0d r=%0d expected d=%0d r=%0d", i, got_data[i], got_resp[i], exp_d[i], exp_r[i]);
      end
    end
    run_write(32'd63, 8'd1, 2, 1, 32'd500);
    checks++;
    if (bresp_got !== RESP_SLVERR) begin errors++; $display("FAIL t5_bresp: got %0d expected 2", bresp_got); end
    run_read(32'd63, 8'd0, 1'b0);
    checks++;
    if (got_data.size() !== 1 || got_data[0] !== 32'd500 || got_resp[0] !== RESP_OKAY) begin
      errors++; $display("FAIL t5_mem63: got %0d expected 500", got_data[0]);
    end
    run_read(32'h0001_0005, 8'd0, 1'b0);
    checks++;
    if (got_data.size() !== 1 || got_data[0] !== 32'd0 || got_resp[0] !== RESP_SLVERR) begin
      errors++; $display("FAIL t5_upper: got d=%0d r=%0d expected d=0 r=2", got_data[0], got_resp[0]);
    end
    run_write(32'd30, 8'd3, 2, 1, 32'd600);
    checks++;
    if (wr_timeout !== 1'b0 || bresp_got !== RESP_SLVERR) begin
      errors++; $display("FAIL t5_early_wlast: got %0d timeout=%b expected 2", bresp_got, wr_timeout);
    end
    run_read(32'd30, 8'd2, 1'b0);
    checks++;
    if (got_data.size() !== 3 || got_data[0] !== 32'd600 || got_data[1] !== 32'd601 || got_data[2] !== 32'd82) begin
      errors++; $display("FAIL t5_early_mem: got %0d,%0d,%0d expected 600,601,82", got_data[0], got_data[1], got_data[2]);
    end
  endtask

  task automatic test_reset_mid_burst();
    arvalid = 1'b1; araddr = 32'd0; arlen = 8'd15; rready = 1'b0;
    awvalid = 1'b1; awaddr = 32'd40; awlen = 8'd7;
    @(posedge sys_clk); #1;
    arvalid = 1'b0; awvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wvalid = 1'b1; wdata = 32'(200 + k); wlast = 1'b0;
      @(posedge sys_clk); #1;
    end
    wvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || wready !== 1'b1) begin
      errors++; $display("FAIL t6_pre: got rvalid=%b wready=%b expected 1 1", rvalid, wready);
    end
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    checks++;
    if ({arready, awready, rvalid, wready, bvalid} !== 5'b11000) begin
      errors++; $display("FAIL t6_ctrl: got %b expected 11000", {arready, awready, rvalid, wready, bvalid});
    end
    checks++;
    if (dut.r_state !== R_IDLE || dut.w_state !== W_IDLE) begin
      errors++; $display("FAIL t6_fsm: got r=%0d w=%0d expected 0 0", dut.r_state, dut.w_state);
    end
    run_read(32'd40, 8'd3, 1'b0);
    checks++;
    if (got_data.size() !== 4 || got_data[0] !== 32'd200 || got_data[1] !== 32'd201 ||
        got_data[2] !== 32'd202 || got_data[3] !== 32'd93) begin
      errors++; $display("FAIL t6_kept: got %0d,%0d,%0d,%0d expected 200,201,202,93", got_data[0], got_data[1], got_data[2], got_data[3]);
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    arvalid = 1'b0; araddr = 32'd0; arlen = 8'd0; rready = 1'b0;
    awvalid = 1'b0; awaddr = 32'd0; awlen = 8'd0;
    wvalid = 1'b0; wdata = 32'd0; wlast = 1'b0; bready = 1'b0;
    test_reset();
    test_single_burst_read();
    test_concurrent();
    test_write_burst();
    test_single_beat();
    test_read_stall();
    test_out_of_range();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
